// File: rtl/dot_matrix_pkg.sv
// ---------------------------------------------------------------------------
// dot_matrix_pkg
//   Constants and types shared by the 16x16 dot-matrix scan driver and its
//   receive-side capture block.
//   - DOT_ROWS / DOT_COLS : matrix geometry
//   - ROW_IDX_W           : width of the row-index bus
//   - cap_state_e         : capture FSM states (HUNT, CAPTURE)
//   - sat_inc8            : saturating 8-bit increment used by error counters
// ---------------------------------------------------------------------------
package dot_matrix_pkg;

    localparam int DOT_ROWS  = 16;
    localparam int DOT_COLS  = 16;
    localparam int ROW_IDX_W = 4;

    typedef logic [DOT_COLS-1:0]  dot_row_t;
    typedef logic [ROW_IDX_W-1:0] row_idx_t;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } cap_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dot_frame_buf.sv
// ---------------------------------------------------------------------------
// dot_frame_buf
//   Dual-bank 16x16 frame store. Rows are written one at a time into the
//   shadow bank; a commit copies the whole frame into the stable bank in a
//   single cycle so readers never observe a half-updated frame.
//   Ports:
//     clock, rst_n  : clock and asynchronous active-low reset
//     wr_en_i       : write wr_data_i into shadow[wr_row_i]
//     wr_row_i      : shadow write row index
//     wr_data_i     : shadow write data (1 = lit)
//     commit_i      : copy shadow (with this cycle's write merged) to stable
//     rd_row_i      : stable-bank read address
//     rd_data_o     : stable-bank read data, registered (1-cycle latency)
// ---------------------------------------------------------------------------
module dot_frame_buf
    import dot_matrix_pkg::*;
(
    input  logic     clock,
    input  logic     rst_n,
    input  logic     wr_en_i,
    input  row_idx_t wr_row_i,
    input  dot_row_t wr_data_i,
    input  logic     commit_i,
    input  row_idx_t rd_row_i,
    output dot_row_t rd_data_o
);

    dot_row_t shadow_q [DOT_ROWS];
    dot_row_t stable_q [DOT_ROWS];
    dot_row_t rdData_q;

    // The row written in the commit cycle (row 15) is forwarded straight into
    // the stable bank, since the shadow copy only lands at the same edge.
    // The read samples the stable bank before the commit takes effect, so a
    // read issued in the commit cycle returns the previous frame.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DOT_ROWS; i++) begin
                shadow_q[i] <= '0;
                stable_q[i] <= '0;
            end
            rdData_q <= '0;
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_row_i] <= wr_data_i;
            end
            if (commit_i) begin
                for (int i = 0; i < DOT_ROWS; i++) begin
                    stable_q[i] <= (wr_en_i && (wr_row_i == row_idx_t'(i))) ? wr_data_i : shadow_q[i];
                end
            end
            rdData_q <= stable_q[rd_row_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/dot_scan_capture.sv
// ---------------------------------------------------------------------------
// dot_scan_capture
//   Receive side of the 16x16 row-scan bus. Rebuilds full frames from the
//   scanned row stream, checks row ordering, and exposes the last good frame.
//   Parameters:
//     ACTIVE_LOW  : 1 = incoming pattern bits are active-low
//     LOCK_FRAMES : consecutive good frames needed before locked (1..15)
//   Ports:
//     clock, rst_n : clock and asynchronous active-low reset
//     scan_valid   : qualifies dot_r / dot_c
//     dot_r, dot_c : row pattern and row index from the scan driver
//     rd_row       : stable-buffer read address
//     rd_data      : stable-buffer row, 1-cycle latency
//     frame_done   : pulse when a good frame is committed
//     frame_xor    : XOR of all rows of the last committed frame
//     frame_count  : committed frames, wrapping
//     sync_err     : pulse on a row-order violation
//     err_count    : violations, saturating at 255
//     locked       : LOCK_FRAMES consecutive good frames seen
// ---------------------------------------------------------------------------
module dot_scan_capture
    import dot_matrix_pkg::*;
#(
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        scan_valid,
    input  logic [15:0] dot_r,
    input  logic [3:0]  dot_c,
    input  logic [3:0]  rd_row,
    output logic [15:0] rd_data,
    output logic        frame_done,
    output logic [15:0] frame_xor,
    output logic [7:0]  frame_count,
    output logic        sync_err,
    output logic [7:0]  err_count,
    output logic        locked
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam row_idx_t   LAST_ROW = row_idx_t'(DOT_ROWS - 1);

    cap_state_e state_q, state_d;
    row_idx_t   exp_q, exp_d;
    dot_row_t   runXor_q, runXor_d;
    dot_row_t   frameXor_q, frameXor_d;
    logic       frameDone_q, frameDone_d;
    logic [7:0] frameCount_q, frameCount_d;
    logic       syncErr_q, syncErr_d;
    logic [7:0] errCount_q, errCount_d;
    logic [3:0] streak_q, streak_d;
    logic       locked_q, locked_d;

    dot_row_t   rowIn;
    logic       wrEn;
    logic       commit;
    logic [3:0] streakInc;

    assign rowIn     = ACTIVE_LOW ? ~dot_r : dot_r;
    assign streakInc = (streak_q == LOCK_N) ? streak_q : streak_q + 4'd1;

    // All capture state and status outputs live in one register bank so that
    // every output changes on the edge that consumes the triggering sample.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            exp_q        <= '0;
            runXor_q     <= '0;
            frameXor_q   <= '0;
            frameDone_q  <= 1'b0;
            frameCount_q <= '0;
            syncErr_q    <= 1'b0;
            errCount_q   <= '0;
            streak_q     <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            runXor_q     <= runXor_d;
            frameXor_q   <= frameXor_d;
            frameDone_q  <= frameDone_d;
            frameCount_q <= frameCount_d;
            syncErr_q    <= syncErr_d;
            errCount_q   <= errCount_d;
            streak_q     <= streak_d;
            locked_q     <= locked_d;
        end
    end

    // Next-state logic. A violation that lands on row 0 restarts the capture
    // in the same cycle instead of losing that row to a trip through HUNT.
    // After a commit the running XOR is cleared so the next frame's row 0
    // starts a fresh accumulation while staying in CAPTURE.
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        runXor_d     = runXor_q;
        frameXor_d   = frameXor_q;
        frameDone_d  = 1'b0;
        frameCount_d = frameCount_q;
        syncErr_d    = 1'b0;
        errCount_d   = errCount_q;
        streak_d     = streak_q;
        locked_d     = locked_q;
        wrEn         = 1'b0;
        commit       = 1'b0;

        if (scan_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (dot_c == '0) begin
                        wrEn     = 1'b1;
                        exp_d    = row_idx_t'(1);
                        runXor_d = rowIn;
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (dot_c == exp_q) begin
                        wrEn = 1'b1;
                        if (exp_q == LAST_ROW) begin
                            commit       = 1'b1;
                            exp_d        = '0;
                            runXor_d     = '0;
                            frameXor_d   = runXor_q ^ rowIn;
                            frameDone_d  = 1'b1;
                            frameCount_d = frameCount_q + 8'd1;
                            streak_d     = streakInc;
                            locked_d     = (streakInc == LOCK_N);
                        end else begin
                            exp_d    = exp_q + row_idx_t'(1);
                            runXor_d = runXor_q ^ rowIn;
                        end
                    end else begin
                        syncErr_d  = 1'b1;
                        errCount_d = sat_inc8(errCount_q);
                        streak_d   = '0;
                        locked_d   = 1'b0;
                        if (dot_c == '0) begin
                            wrEn     = 1'b1;
                            exp_d    = row_idx_t'(1);
                            runXor_d = rowIn;
                        end else begin
                            exp_d    = '0;
                            runXor_d = '0;
                            state_d  = HUNT;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    dot_frame_buf u_buf (
        .clock     (clock),
        .rst_n     (rst_n),
        .wr_en_i   (wrEn),
        .wr_row_i  (dot_c),
        .wr_data_i (rowIn),
        .commit_i  (commit),
        .rd_row_i  (rd_row),
        .rd_data_o (rd_data)
    );

    assign frame_done  = frameDone_q;
    assign frame_xor   = frameXor_q;
    assign frame_count = frameCount_q;
    assign sync_err    = syncErr_q;
    assign err_count   = errCount_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_dot_scan_capture.sv
// ---------------------------------------------------------------------------
// tb_dot_scan_capture
//   Self-checking bench for dot_scan_capture. A frame-level reference model
//   (partial frame kept as a queue of rows) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_dot_scan_capture;

    localparam bit ACTIVE_LOW = 1'b1;
    localparam int LOCK       = 2;

    logic        clock;
    logic        rst_n;
    logic        scanValid;
    logic [15:0] dotR;
    logic [3:0]  dotC;
    logic [3:0]  rdRow;
    logic [15:0] rdData;
    logic        frameDone;
    logic [15:0] frameXor;
    logic [7:0]  frameCount;
    logic        syncErr;
    logic [7:0]  errCount;
    logic        lockedO;

    dot_scan_capture #(
        .ACTIVE_LOW  (ACTIVE_LOW),
        .LOCK_FRAMES (LOCK)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .scan_valid  (scanValid),
        .dot_r       (dotR),
        .dot_c       (dotC),
        .rd_row      (rdRow),
        .rd_data     (rdData),
        .frame_done  (frameDone),
        .frame_xor   (frameXor),
        .frame_count (frameCount),
        .sync_err    (syncErr),
        .err_count   (errCount),
        .locked      (lockedO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int doneSeen = 0;
    int errSeen  = 0;

    // Reference model state
    logic        mHunting;
    logic [15:0] mPart[$];
    logic [15:0] mStable[16];
    logic [15:0] mXor;
    logic [7:0]  mCount;
    logic [7:0]  mErrCnt;
    int          mStreak;
    logic        mLocked;
    logic        mDone;
    logic        mErr;
    logic [15:0] expRd;

    logic [15:0] glyph[16];
    logic [15:0] frameB[16];

    typedef struct {
        logic        v;
        logic [3:0]  c;
        logic [15:0] r;
        logic [3:0]  rr;
        logic        expDone;
        logic [7:0]  expCount;
        logic        expLocked;
        logic        chkRd;
        logic [15:0] expRdv;
    } vec_t;
    vec_t tbl[18];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mHunting = 1'b1;
        mPart.delete();
        for (int k = 0; k < 16; k++) mStable[k] = '0;
        mXor = '0; mCount = '0; mErrCnt = '0; mStreak = 0; mLocked = 1'b0;
        mDone = 1'b0; mErr = 1'b0;
    endtask

    task automatic modelUpdate(input logic v, input logic [15:0] r, input logic [3:0] c);
        logic [15:0] row;
        mDone = 1'b0;
        mErr  = 1'b0;
        if (!v) return;
        row = ACTIVE_LOW ? ~r : r;
        if (mHunting) begin
            if (c == 4'd0) begin
                mPart.delete();
                mPart.push_back(row);
                mHunting = 1'b0;
            end
        end else if (int'(c) == mPart.size()) begin
            mPart.push_back(row);
            if (mPart.size() == 16) begin
                mXor = '0;
                for (int k = 0; k < 16; k++) begin
                    mStable[k] = mPart[k];
                    mXor ^= mPart[k];
                end
                mCount++;
                if (mStreak < LOCK) mStreak++;
                mLocked = (mStreak >= LOCK);
                mDone = 1'b1;
                mPart.delete();
            end
        end else begin
            mErr = 1'b1;
            if (mErrCnt != 8'hFF) mErrCnt++;
            mStreak = 0;
            mLocked = 1'b0;
            mPart.delete();
            if (c == 4'd0) mPart.push_back(row);
            else mHunting = 1'b1;
        end
    endtask

    task automatic checkOutput();
        check("rd_data", rdData, expRd);
        check("frame_done", 16'(frameDone), 16'(mDone));
        check("sync_err", 16'(syncErr), 16'(mErr));
        check("frame_count", 16'(frameCount), 16'(mCount));
        check("err_count", 16'(errCount), 16'(mErrCnt));
        check("locked", 16'(lockedO), 16'(mLocked));
        check("frame_xor", frameXor, mXor);
        if (frameDone) doneSeen++;
        if (syncErr) errSeen++;
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, sample 1 ns later.
    task automatic applyStimulus(input logic v, input logic [15:0] r, input logic [3:0] c, input logic [3:0] rr);
        scanValid = v; dotR = r; dotC = c; rdRow = rr;
        expRd = mStable[rr];
        @(posedge clock);
        modelUpdate(v, r, c);
        #1;
        checkOutput();
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        scanValid = 1'b0;
        #2;
        modelReset();
        check("reset_rd_data", rdData, 16'h0);
        check("reset_frame_done", 16'(frameDone), 16'h0);
        check("reset_frame_xor", frameXor, 16'h0);
        check("reset_frame_count", 16'(frameCount), 16'h0);
        check("reset_sync_err", 16'(syncErr), 16'h0);
        check("reset_err_count", 16'(errCount), 16'h0);
        check("reset_locked", 16'(lockedO), 16'h0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        doneSeen = 0;
        errSeen  = 0;
    endtask

    task automatic sendFrame(input logic [15:0] rows[16], input logic [3:0] rr);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, rows[i], 4'(i), rr);
    endtask

    initial begin
        logic [15:0] expX;
        logic [3:0]  nextC;
        logic        v;
        logic [3:0]  c;

        glyph = '{16'hFFFF, 16'hE03F, 16'hC07F, 16'hCF3F, 16'hCF3F, 16'hBFFD, 16'h8001, 16'h8001,
                  16'h8181, 16'h8181, 16'h8001, 16'h8001, 16'h8001, 16'hC003, 16'hFFFF, 16'hFFFF};

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{1'b1, 4'(i), glyph[i], 4'd0, (i == 15), (i == 15) ? 8'd1 : 8'd0, 1'b0, 1'b0, 16'h0};
        end
        tbl[16] = '{1'b0, 4'd0, 16'h0, 4'd2, 1'b0, 8'd1, 1'b0, 1'b1, 16'h3F80};
        tbl[17] = '{1'b0, 4'd0, 16'h0, 4'd5, 1'b0, 8'd1, 1'b0, 1'b1, 16'h4002};

        scanValid = 1'b0; dotR = '0; dotC = '0; rdRow = '0;
        rst_n = 1'b0;
        modelReset();
        #1;
        applyReset();

        // Clean scan from the vector table
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].rr);
            check("tbl_frame_done", 16'(frameDone), 16'(tbl[i].expDone));
            check("tbl_frame_count", 16'(frameCount), 16'(tbl[i].expCount));
            check("tbl_locked", 16'(lockedO), 16'(tbl[i].expLocked));
            if (tbl[i].chkRd) check("tbl_rd_data", rdData, tbl[i].expRdv);
        end
        check("clean_done_once", 16'(doneSeen), 16'd1);

        // Lock acquisition over three back-to-back frames
        applyReset();
        sendFrame(glyph, 4'd0);
        check("lock_after_f1", 16'(lockedO), 16'h0);
        sendFrame(glyph, 4'd0);
        check("lock_after_f2", 16'(lockedO), 16'h1);
        sendFrame(glyph, 4'd0);
        check("lock_count", 16'(frameCount), 16'd3);
        check("lock_no_err", 16'(errSeen), 16'd0);

        // Skipped row, then a clean frame
        applyReset();
        applyStimulus(1'b1, 16'h1111, 4'd0, 4'd0);
        applyStimulus(1'b1, 16'h2222, 4'd1, 4'd0);
        applyStimulus(1'b1, 16'h3333, 4'd2, 4'd0);
        applyStimulus(1'b1, 16'h4444, 4'd4, 4'd0);
        check("skip_sync_err", 16'(syncErr), 16'h1);
        check("skip_err_count", 16'(errCount), 16'd1);
        for (int i = 0; i < 16; i++) frameB[i] = 16'($urandom);
        sendFrame(frameB, 4'd0);
        check("skip_done_once", 16'(doneSeen), 16'd1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 16'h0, 4'd0, 4'(i));
            check("skip_stable_row", rdData, ~frameB[i]);
        end

        // Start mid-frame
        applyReset();
        for (int i = 7; i < 16; i++) applyStimulus(1'b1, glyph[i], 4'(i), 4'd0);
        check("mid_no_done", 16'(doneSeen), 16'd0);
        check("mid_no_err", 16'(errSeen), 16'd0);
        sendFrame(glyph, 4'd0);
        check("mid_done_once", 16'(doneSeen), 16'd1);

        // Gaps inside a frame with a concurrent read of row 0
        applyReset();
        sendFrame(glyph, 4'd0);
        for (int i = 0; i < 16; i++) frameB[i] = 16'($urandom);
        expX = '0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, frameB[i], 4'(i), 4'd0);
            if (i == 5) for (int g = 0; g < 3; g++) applyStimulus(1'b0, 16'($urandom), 4'(g + 9), 4'd0);
            expX ^= ~frameB[i];
        end
        check("gap_rd_old", rdData, ~glyph[0]);
        applyStimulus(1'b0, 16'h0, 4'd0, 4'd0);
        check("gap_rd_new", rdData, ~frameB[0]);
        check("gap_xor", frameXor, expX);
        check("gap_count", 16'(frameCount), 16'd2);

        // Reset in the middle of a frame
        applyReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, glyph[i], 4'(i), 4'd0);
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 4'd0, 4'd0);
        check("rst_no_done", 16'(doneSeen), 16'd0);
        sendFrame(glyph, 4'd0);
        check("rst_done_once", 16'(doneSeen), 16'd1);
        check("rst_count", 16'(frameCount), 16'd1);

        // Randomized stream: mostly in-order rows with gaps and occasional jumps
        applyReset();
        nextC = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0) ? 4'($urandom) : nextC;
            if (v) nextC = c + 4'd1;
            applyStimulus(v, 16'($urandom), c, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_scan_capture.md
Name: dot_scan_capture

Overview:
- Receive-side counterpart of the 16x16 dot-matrix row-scan driver.
- Samples the scanned row-pattern/row-index bus, rebuilds complete 16x16 frames, and checks the scan sequence for order errors.
- Holds the last good frame in a readable buffer for self-check logic and for a second display or bridge.
- Sits on the same clock as the scan driver and connects directly to its row-pattern and row-index outputs.

Parameters:
- ACTIVE_LOW, 1, 1 = incoming pattern bits are active-low (0 = lit); stored data is always 1 = lit.
- LOCK_FRAMES, 2, number of consecutive good frames required before `locked` asserts (range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scan_valid  in  1  qualifies dot_r/dot_c this cycle.
- dot_r  in  16  row pattern from the scan driver.
- dot_c  in  4  row index from the scan driver.
- rd_row  in  4  read address into the stable frame buffer.
- rd_data  out  16  stable-buffer row; registered, 1-cycle latency.
- frame_done  out  1  one-cycle pulse when a good frame is committed.
- frame_xor  out  16  XOR of all 16 stored (1 = lit) rows of the last committed frame.
- frame_count  out  8  committed-frame counter; wraps 255 -> 0.
- sync_err  out  1  one-cycle pulse on a sequence violation.
- err_count  out  8  sequence-violation counter; saturates at 255.
- locked  out  1  high after LOCK_FRAMES consecutive good frames.

Behaviour:
- Reset values: rd_data=0, frame_done=0, frame_xor=0, frame_count=0, sync_err=0, err_count=0, locked=0.
- Reset state: FSM in HUNT; both buffers cleared to 0.
- Reset is asynchronous and may assert at any point. Mid-frame reset discards the partial frame, and no frame_done fires afterwards for it.
- Data normalisation: row_in = ACTIVE_LOW ? ~dot_r : dot_r.
- Cycles with scan_valid=0 are ignored entirely: no state change and no expectation advance. Gaps inside a frame are legal.
- HUNT state:
  - Wait for a valid sample with dot_c==0.
  - On that sample: write row_in to shadow[0], set exp=1, set the running xor to row_in, and go to CAPTURE.
  - Any other valid sample is discarded without raising sync_err.
- CAPTURE state:
  - On a valid sample with dot_c==exp: write row_in to shadow[exp] and XOR it into the running xor.
  - If exp==15, commit the frame and set exp=0; the state stays CAPTURE, expecting the next frame's row 0.
  - Otherwise exp=exp+1.
  - On a valid sample with dot_c!=exp: pulse sync_err and increment err_count (saturating). Also clear the good-frame streak, drop locked, and discard the partial frame.
  - After a violation: if dot_c==0, restart the capture in the same cycle (shadow[0] written, exp=1). Otherwise go to HUNT.
- Commit (on the row-15 sample cycle; outputs visible the next cycle):
  - Copy shadow rows 0..14 plus the incoming row 15 into the stable buffer.
  - Update frame_xor to the final running xor.
  - Pulse frame_done and increment frame_count (wrapping).
  - Increment the streak counter, saturating at LOCK_FRAMES. Set locked when streak==LOCK_FRAMES.
- Reads:
  - rd_data <= stable[rd_row] every cycle, independent of scan_valid.
  - A read in the cycle after a commit returns the new frame.
  - A read in the commit cycle itself returns the old frame.
  - A torn read is never possible.
- sync_err and frame_done are never asserted in the same cycle, because a violation cannot also be a row-15 match.

Decomposition:
- Shared package dot_matrix_pkg: constants DOT_ROWS=16 and DOT_COLS=16, the row-index width (4), and the FSM state enum {HUNT, CAPTURE}. The existing scan driver also moves onto these constants.
- One sub-module: dot_frame_buf.
  - 16x16 dual bank (shadow + stable) with a single-cycle commit.
  - Write port: row index + data. Read port: registered.

Test Plan:
- Clean scan: after reset, drive rows 0..15 back-to-back with the lock-glyph pattern, ACTIVE_LOW=1, scan_valid=1. Required: frame_done pulses exactly once, on the cycle after row 15. frame_count=1, locked=0. Reading rd_row=2 returns ~16'hC07F = 16'h3F80.
- Lock acquisition: three continuous frames, LOCK_FRAMES=2. Required: locked rises the cycle after the second row 15, frame_count=3, sync_err never asserts.
- Skipped row: sequence 0,1,2,4, then 0..15. Required: sync_err pulses on the row-4 sample and err_count=1. No frame_done until the following clean row 15, after which the stable buffer holds the new frame only.
- Start mid-frame: begin at row 7 after reset. Required: rows 7..15 are discarded with no sync_err and no frame_done. The first frame_done occurs after the next full 0..15.
- Gaps plus a concurrent read: insert scan_valid=0 for 3 cycles between rows 5 and 6, and hold rd_row=0 throughout. Required: the frame still commits. rd_data shows the old row 0 until the cycle after commit, then the new one. frame_xor equals the XOR of all 16 rows.
- Reset mid-frame: assert rst_n=0 after row 9, release, then send a full frame. Required: all outputs are 0 during reset, and exactly one frame_done occurs with frame_count=1.
